// File: rtl/nic_filter_pkg.sv
// nic_filter_pkg: shared types and constants for the RX MAC filter
package nic_filter_pkg;
  typedef enum logic [2:0] {
    R_NOMATCH  = 3'd0,
    R_RUNT     = 3'd1,
    R_OVERSIZE = 3'd2,
    R_PROMISC  = 3'd3,
    R_ABORT    = 3'd4,
    R_MATCH    = 3'd5,
    R_BCAST    = 3'd6,
    R_MCAST    = 3'd7
  } reason_t;
  typedef enum logic {IDLE, IN_PKT} state_t;
  localparam int MIN_FRAME = 60;
  localparam int HDR_OVERHEAD = 18;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
endpackage

// File: rtl/nic_mac_table.sv
// nic_mac_table: shadow/active MAC table with packet-safe commit and registered lookup
module nic_mac_table #(
  parameter int NUM_MACS = 4,
  parameter int IDX_W    = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [47:0]      mac_i,
  input  logic             en_i,
  input  logic             commit_i,
  input  logic             lookup_i,
  input  logic [47:0]      dst_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [47:0] sh_mac_q [NUM_MACS];
  logic [47:0] act_mac_q [NUM_MACS];
  logic [NUM_MACS-1:0] sh_en_q, act_en_q;
  logic hit_d, hit_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  // shadow takes writes (out-of-range indices match no entry); active copies shadow only between packets
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      sh_mac_q <= '{default: '0};
      act_mac_q <= '{default: '0};
      sh_en_q <= '0;
      act_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_MACS; i++)
        if (we_i && idx_i == IDX_W'(i)) begin
          sh_mac_q[i] <= mac_i;
          sh_en_q[i] <= en_i;
        end
      if (commit_i) begin
        act_mac_q <= sh_mac_q;
        act_en_q <= sh_en_q;
      end
    end
  // lowest enabled matching entry wins
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = NUM_MACS - 1; i >= 0; i--)
      if (act_en_q[i] && act_mac_q[i] == dst_i) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(i);
      end
  end
  // lookup result captured on the sop beat and held for the packet
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      hit_q <= 1'b0;
      idx_q <= '0;
    end else if (lookup_i) begin
      hit_q <= hit_d;
      idx_q <= idx_d;
    end
  assign hit_o = hit_q;
  assign idx_o = idx_q;
endmodule

// File: rtl/nic_rx_mac_filter.sv
// nic_rx_mac_filter: per-packet RX destination/size filter with saturating accept/drop counters
module nic_rx_mac_filter
  import nic_filter_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_MACS = 4,
  parameter int IDX_W    = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1,
  parameter int EMPTY_W  = $clog2(DATA_W / 8)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [DATA_W-1:0]  rx_data_i,
  input  logic               rx_valid_i,
  input  logic               rx_ready_i,
  input  logic               rx_sop_i,
  input  logic               rx_eop_i,
  input  logic [EMPTY_W-1:0] rx_empty_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [47:0]        cfg_mac_i,
  input  logic               cfg_en_i,
  input  logic               cfg_promisc_i,
  input  logic               cfg_bcast_en_i,
  input  logic               cfg_mcast_en_i,
  input  logic [15:0]        cfg_mtu_i,
  input  logic               cnt_clr_i,
  output logic               dec_valid_o,
  output logic               dec_accept_o,
  output logic               dec_hit_o,
  output logic [IDX_W-1:0]   dec_idx_o,
  output logic [2:0]         dec_reason_o,
  output logic [31:0]        accept_cnt_o,
  output logic [31:0]        drop_cnt_o
);
  localparam int BYTES = DATA_W / 8;
  state_t state_q, state_d;
  reason_t reason_c, reason_q;
  logic beat, sop, eop_done, abort, commit;
  logic [15:0] bytes_c, len_d, len_q, mtu_q;
  logic [16:0] sum_c;
  logic [47:0] dst_q;
  logic promisc_q, bcast_en_q, mcast_en_q, pend_q, abort_q;
  logic hit, is_bcast, is_mcast, oversize, acc_c, dhit_c, acc_q, hit_q;
  logic [IDX_W-1:0] idx, didx_c, idx_q;
  logic [31:0] acc_cnt_q, drop_cnt_q;
  logic unused_data;
  assign unused_data = ^rx_data_i[DATA_W-49:0];
  assign beat = rx_valid_i && rx_ready_i;
  assign sop = beat && rx_sop_i;
  assign eop_done = beat && rx_eop_i && (rx_sop_i || state_q == IN_PKT);
  assign abort = sop && state_q == IN_PKT;
  assign commit = state_q == IDLE && !sop;
  assign bytes_c = rx_eop_i ? 16'(BYTES) - 16'(rx_empty_i) : 16'(BYTES);
  assign sum_c = {1'b0, sop ? 16'd0 : len_q} + {1'b0, bytes_c};
  assign len_d = sum_c[16] ? 16'hFFFF : sum_c[15:0];
  nic_mac_table #(.NUM_MACS(NUM_MACS), .IDX_W(IDX_W)) u_table (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (cfg_we_i),
    .idx_i    (cfg_idx_i),
    .mac_i    (cfg_mac_i),
    .en_i     (cfg_en_i),
    .commit_i (commit),
    .lookup_i (sop),
    .dst_i    (rx_data_i[DATA_W-1 -: 48]),
    .hit_o    (hit),
    .idx_o    (idx)
  );
  // any accepted sop opens a packet unless the same beat closes it
  always_comb begin
    state_d = state_q;
    if (sop) state_d = rx_eop_i ? IDLE : IN_PKT;
    else if (eop_done) state_d = IDLE;
  end
  // packet context: state, destination, config snapshot, length and pending decision
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      dst_q <= '0;
      promisc_q <= 1'b0;
      bcast_en_q <= 1'b0;
      mcast_en_q <= 1'b0;
      mtu_q <= '0;
      len_q <= '0;
      pend_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= eop_done || abort;
      abort_q <= abort;
      if (sop) begin
        dst_q <= rx_data_i[DATA_W-1 -: 48];
        promisc_q <= cfg_promisc_i;
        bcast_en_q <= cfg_bcast_en_i;
        mcast_en_q <= cfg_mcast_en_i;
        mtu_q <= cfg_mtu_i;
      end
      if (sop || (beat && state_q == IN_PKT)) len_q <= len_d;
    end
  assign is_bcast = dst_q == BCAST_MAC;
  assign is_mcast = dst_q[40] && !is_bcast;
  assign oversize = {1'b0, len_q} > {1'b0, mtu_q} + 17'(HDR_OVERHEAD);
  // prioritised decision for the packet that just closed or was aborted
  always_comb begin
    reason_c = abort_q ? R_ABORT :
               len_q < 16'(MIN_FRAME) ? R_RUNT :
               oversize ? R_OVERSIZE :
               hit ? R_MATCH :
               (is_bcast && bcast_en_q) ? R_BCAST :
               (is_mcast && mcast_en_q) ? R_MCAST :
               promisc_q ? R_PROMISC : R_NOMATCH;
    acc_c = reason_c inside {R_MATCH, R_BCAST, R_MCAST, R_PROMISC};
    dhit_c = hit && !abort_q;
    didx_c = abort_q ? '0 : idx;
  end
  // hold the last decision between strobes
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      acc_q <= 1'b0;
      hit_q <= 1'b0;
      idx_q <= '0;
      reason_q <= R_NOMATCH;
    end else if (pend_q) begin
      acc_q <= acc_c;
      hit_q <= dhit_c;
      idx_q <= didx_c;
      reason_q <= reason_c;
    end
  // saturating counters; a clear beats a same-cycle increment
  always_ff @(posedge clk_i)
    if (!rst_n_i || cnt_clr_i) begin
      acc_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (pend_q) begin
      if (acc_c && acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + 32'd1;
      if (!acc_c && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  assign dec_valid_o = pend_q;
  assign dec_accept_o = pend_q ? acc_c : acc_q;
  assign dec_hit_o = pend_q ? dhit_c : hit_q;
  assign dec_idx_o = pend_q ? didx_c : idx_q;
  assign dec_reason_o = pend_q ? reason_c : reason_q;
  assign accept_cnt_o = acc_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_nic_rx_mac_filter.sv
// tb_nic_rx_mac_filter: scoreboard bench for the RX MAC filter
module tb_nic_rx_mac_filter;
  typedef struct packed {
    logic       acc;
    logic       hit;
    logic [1:0] idx;
    logic [2:0] reason;
    logic       chk;
  } exp_t;
  localparam logic [47:0] M2 = 48'h0011_2233_4455;
  localparam logic [47:0] MY = 48'h00AA_BBCC_DD00;
  localparam logic [47:0] MZ = 48'h00AA_BBCC_DD0F;
  localparam logic [47:0] MU = 48'h0200_0000_0009;
  localparam logic [47:0] MB = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MM = 48'h0100_5E00_0001;
  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] rx_data;
  logic rx_valid, rx_ready, rx_sop, rx_eop;
  logic [2:0] rx_empty;
  logic cfg_we, cfg_en, cfg_promisc, cfg_bcast_en, cfg_mcast_en, cnt_clr;
  logic [1:0] cfg_idx;
  logic [47:0] cfg_mac;
  logic [15:0] cfg_mtu;
  logic dec_valid_o, dec_accept_o, dec_hit_o;
  logic [1:0] dec_idx_o;
  logic [2:0] dec_reason_o;
  logic [31:0] accept_cnt_o, drop_cnt_o;
  logic [31:0] exp_acc, exp_drop;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  nic_rx_mac_filter #(.DATA_W(64), .NUM_MACS(3)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_i     (rx_ready),
    .rx_sop_i       (rx_sop),
    .rx_eop_i       (rx_eop),
    .rx_empty_i     (rx_empty),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_mac_i      (cfg_mac),
    .cfg_en_i       (cfg_en),
    .cfg_promisc_i  (cfg_promisc),
    .cfg_bcast_en_i (cfg_bcast_en),
    .cfg_mcast_en_i (cfg_mcast_en),
    .cfg_mtu_i      (cfg_mtu),
    .cnt_clr_i      (cnt_clr),
    .dec_valid_o    (dec_valid_o),
    .dec_accept_o   (dec_accept_o),
    .dec_hit_o      (dec_hit_o),
    .dec_idx_o      (dec_idx_o),
    .dec_reason_o   (dec_reason_o),
    .accept_cnt_o   (accept_cnt_o),
    .drop_cnt_o     (drop_cnt_o)
  );
  task automatic drive_beat(input logic v, input logic r, input logic s, input logic e, input logic [2:0] emp, input logic [63:0] d);
    rx_valid = v;
    rx_ready = r;
    rx_sop = s;
    rx_eop = e;
    rx_empty = emp;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic write_entry(input logic [1:0] i, input logic [47:0] m, input logic en);
    cfg_we = 1'b1;
    cfg_idx = i;
    cfg_mac = m;
    cfg_en = en;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    idle(2);
  endtask
  task automatic send_pkt(input string nm, input logic [47:0] dst, input int len, input exp_t e, input int wr_beat, input logic stall, input logic clr);
    int nb;
    exp_t g;
    nb = (len + 7) / 8;
    sb.push_back(e);
    for (int b = 0; b < nb; b++) begin
      if (stall && b == 1) drive_beat(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, {MU, 16'h0800});
      cfg_we = (b == wr_beat);
      drive_beat(1'b1, 1'b1, b == 0, b == nb - 1, b == nb - 1 ? 3'(nb * 8 - len) : 3'd0,
                 b == 0 ? {dst, 16'h0800} : {$urandom, $urandom});
    end
    cfg_we = 1'b0;
    rx_valid = 1'b0;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    cnt_clr = clr;
    checks++;
    if (dec_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s dec_valid got %b want 1", nm, dec_valid_o);
    end
    g = sb.pop_front();
    checks++;
    if (dec_accept_o !== g.acc || dec_reason_o !== g.reason || (g.chk && (dec_hit_o !== g.hit || dec_idx_o !== g.idx))) begin
      errors++;
      $display("FAIL %s decision got acc=%b hit=%b idx=%0d reason=%0d want acc=%b hit=%b idx=%0d reason=%0d",
               nm, dec_accept_o, dec_hit_o, dec_idx_o, dec_reason_o, g.acc, g.hit, g.idx, g.reason);
    end
    if (clr) begin
      exp_acc = '0;
      exp_drop = '0;
    end else if (g.acc) exp_acc = (exp_acc == '1) ? exp_acc : exp_acc + 1;
    else exp_drop = (exp_drop == '1) ? exp_drop : exp_drop + 1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checks++;
    if (dec_valid_o !== 1'b0 || dec_reason_o !== g.reason || accept_cnt_o !== exp_acc || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL %s after got valid=%b reason=%0d acc_cnt=%h drop_cnt=%h want 0 %0d %h %h",
               nm, dec_valid_o, dec_reason_o, accept_cnt_o, drop_cnt_o, g.reason, exp_acc, exp_drop);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dec_valid_o, dec_accept_o, dec_hit_o, dec_idx_o, dec_reason_o, accept_cnt_o, drop_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %b %b %b %0d %0d %h %h want all 0",
               dec_valid_o, dec_accept_o, dec_hit_o, dec_idx_o, dec_reason_o, accept_cnt_o, drop_cnt_o);
    end
    rst_n = 1'b1;
    exp_acc = '0;
    exp_drop = '0;
    idle(1);
  endtask
  task automatic test_reset_mid;
    write_entry(2'd2, M2, 1'b1);
    for (int b = 0; b < 3; b++) drive_beat(1'b1, 1'b1, b == 0, 1'b0, 3'd0, b == 0 ? {M2, 16'h0800} : {$urandom, $urandom});
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) drive_beat(1'b1, 1'b1, 1'b0, b == 2, 3'd0, {$urandom, $urandom});
    idle(1);
    checks++;
    if (dec_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid stray decision got %b want 0", dec_valid_o);
    end
    send_pkt("reset_clears_table", M2, 64, {1'b0, 1'b0, 2'd0, 3'd0, 1'b1}, -1, 1'b0, 1'b0);
  endtask
  task automatic test_unicast;
    write_entry(2'd2, M2, 1'b1);
    send_pkt("unicast", M2, 64, {1'b1, 1'b1, 2'd2, 3'd5, 1'b1}, -1, 1'b0, 1'b0);
    checks++;
    if (accept_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL unicast_cnt got %0d want 1", accept_cnt_o);
    end
  endtask
  task automatic test_table_prio;
    write_entry(2'd1, MY, 1'b1);
    write_entry(2'd0, MY, 1'b1);
    write_entry(2'd3, MZ, 1'b1);
    send_pkt("lowest_idx", MY, 64, {1'b1, 1'b1, 2'd0, 3'd5, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("idx_out_of_range", MZ, 64, {1'b0, 1'b0, 2'd0, 3'd0, 1'b1}, -1, 1'b0, 1'b0);
  endtask
  task automatic test_size;
    send_pkt("runt59", M2, 59, {1'b0, 1'b1, 2'd2, 3'd1, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("min60", M2, 60, {1'b1, 1'b1, 2'd2, 3'd5, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("over1519", M2, 1519, {1'b0, 1'b1, 2'd2, 3'd2, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("max1518_stall", M2, 1518, {1'b1, 1'b1, 2'd2, 3'd5, 1'b1}, -1, 1'b1, 1'b0);
  endtask
  task automatic test_policy;
    send_pkt("bcast_off", MB, 64, {1'b0, 1'b0, 2'd0, 3'd0, 1'b1}, -1, 1'b0, 1'b0);
    cfg_bcast_en = 1'b1;
    send_pkt("bcast_on", MB, 64, {1'b1, 1'b0, 2'd0, 3'd6, 1'b1}, -1, 1'b0, 1'b0);
    cfg_bcast_en = 1'b0;
    cfg_mcast_en = 1'b1;
    send_pkt("mcast_on", MM, 64, {1'b1, 1'b0, 2'd0, 3'd7, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("bcast_not_mcast", MB, 64, {1'b0, 1'b0, 2'd0, 3'd0, 1'b1}, -1, 1'b0, 1'b0);
    cfg_mcast_en = 1'b0;
    cfg_promisc = 1'b1;
    send_pkt("promisc", MU, 64, {1'b1, 1'b0, 2'd0, 3'd3, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("promisc_runt", MU, 40, {1'b0, 1'b0, 2'd0, 3'd1, 1'b1}, -1, 1'b0, 1'b0);
    cfg_promisc = 1'b0;
  endtask
  task automatic test_abort;
    exp_t g;
    sb.push_back({1'b0, 1'b0, 2'd0, 3'd4, 1'b0});
    for (int b = 0; b < 3; b++) drive_beat(1'b1, 1'b1, b == 0, 1'b0, 3'd0, b == 0 ? {MY, 16'h0800} : {$urandom, $urandom});
    sb.push_back({1'b1, 1'b1, 2'd2, 3'd5, 1'b1});
    drive_beat(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, {M2, 16'h0800});
    g = sb.pop_front();
    checks++;
    if (dec_valid_o !== 1'b1 || dec_accept_o !== g.acc || dec_reason_o !== g.reason) begin
      errors++;
      $display("FAIL abort got valid=%b acc=%b reason=%0d want 1 %b %0d", dec_valid_o, dec_accept_o, dec_reason_o, g.acc, g.reason);
    end
    exp_drop = exp_drop + 1;
    for (int b = 1; b < 8; b++) drive_beat(1'b1, 1'b1, 1'b0, b == 7, 3'd0, {$urandom, $urandom});
    rx_valid = 1'b0;
    rx_eop = 1'b0;
    g = sb.pop_front();
    checks++;
    if (dec_valid_o !== 1'b1 || dec_accept_o !== g.acc || dec_hit_o !== g.hit || dec_idx_o !== g.idx || dec_reason_o !== g.reason) begin
      errors++;
      $display("FAIL after_abort got valid=%b acc=%b hit=%b idx=%0d reason=%0d want 1 %b %b %0d %0d",
               dec_valid_o, dec_accept_o, dec_hit_o, dec_idx_o, dec_reason_o, g.acc, g.hit, g.idx, g.reason);
    end
    exp_acc = exp_acc + 1;
    idle(1);
    checks++;
    if (accept_cnt_o !== exp_acc || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL abort_cnt got %h %h want %h %h", accept_cnt_o, drop_cnt_o, exp_acc, exp_drop);
    end
  endtask
  task automatic test_commit;
    cfg_idx = 2'd2;
    cfg_mac = M2;
    cfg_en = 1'b0;
    send_pkt("commit_current", M2, 64, {1'b1, 1'b1, 2'd2, 3'd5, 1'b1}, 3, 1'b0, 1'b0);
    idle(2);
    send_pkt("commit_next", M2, 64, {1'b0, 1'b0, 2'd0, 3'd0, 1'b1}, -1, 1'b0, 1'b0);
  endtask
  task automatic test_saturation;
    idle(1);
    dut.acc_cnt_q = 32'hFFFF_FFFE;
    exp_acc = 32'hFFFF_FFFE;
    cfg_promisc = 1'b1;
    send_pkt("sat1", MU, 64, {1'b1, 1'b0, 2'd0, 3'd3, 1'b1}, -1, 1'b0, 1'b0);
    send_pkt("sat2", MU, 64, {1'b1, 1'b0, 2'd0, 3'd3, 1'b1}, -1, 1'b0, 1'b0);
    checks++;
    if (accept_cnt_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sat_hold got %h want ffffffff", accept_cnt_o);
    end
    send_pkt("clear_wins", MU, 64, {1'b1, 1'b0, 2'd0, 3'd3, 1'b1}, -1, 1'b0, 1'b1);
    cfg_promisc = 1'b0;
    send_pkt("after_clear", MU, 64, {1'b0, 1'b0, 2'd0, 3'd0, 1'b1}, -1, 1'b0, 1'b0);
  endtask
  initial begin
    rst_n = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    rx_ready = 1'b1;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    rx_empty = '0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_mac = '0;
    cfg_en = 1'b0;
    cfg_promisc = 1'b0;
    cfg_bcast_en = 1'b0;
    cfg_mcast_en = 1'b0;
    cfg_mtu = 16'd1500;
    cnt_clr = 1'b0;
    test_reset;
    test_reset_mid;
    test_unicast;
    test_table_prio;
    test_size;
    test_policy;
    test_abort;
    test_commit;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
